switch_conditioner: RTL and testbench
=====================================

// Module: switch_conditioner
// PURPOSE
//   Conditions the raw 4-bit board DIP switches before they reach the CPU input port (io.switch).
//   - Each bit passes through a synchronizer, then a per-bit debounce filter.
//   - The filtered value drives io.switch, which the ALU reads for IN instructions.
//   - Also emits a one-cycle change strobe for the board logic.
// PARAMETERS
//   WIDTH          4      number of switch bits
//   SYNC_STAGES    2      synchronizer flop depth, >= 2
//   STABLE_CYCLES  50000  consecutive cycles a new level must hold before acceptance, >= 1
// PORTS
//   clk         in   1      system clock (same clock as ctrl.clk)
//   rst_n       in   1      asynchronous, active-low reset
//   sw_raw      in   WIDTH  raw asynchronous switch pins
//   sw_out      out  WIDTH  debounced value; connects to io.switch
//   sw_changed  out  1      one-cycle pulse when any sw_out bit changes
//   sw_rise     out  WIDTH  per-bit 0->1 pulse (present only with SWITCH_EDGE_EN)
// BEHAVIOUR
//   - Reset (async assert, sync release by the board): all synchronizer flops, counters,
//     sw_out, sw_changed and sw_rise go to 0.
//   - Synchronizer: sw_raw is shifted through SYNC_STAGES flops; the last stage is sync[i].
//   - Per-bit counter: width $clog2(STABLE_CYCLES+1), saturation-free by construction.
//   - Per-bit FSM:
//     - STABLE: sync[i]==sw_out[i]; counter held at 0.
//       - Go to PENDING when sync[i]!=sw_out[i]; counter <= 1 that same cycle.
//     - PENDING: while sync[i]!=sw_out[i], counter increments each cycle.
//       - When counter==STABLE_CYCLES and the bit still differs: sw_out[i] <= sync[i],
//         counter <= 0, go to STABLE.
//       - If sync[i]==sw_out[i] at any cycle (glitch): counter <= 0, go to STABLE, no output change.
//   - Latency: a clean level change on sw_raw reaches sw_out after
//     SYNC_STAGES + STABLE_CYCLES + 1 clock edges.
//   - STABLE_CYCLES=1: accepted on the cycle after the first differing sample.
//   - Bits are fully independent.
//     - Simultaneous changes on several bits update in the same cycle when their counters expire together.
//     - sw_changed is still a single one-cycle pulse in that case.
//   - sw_changed: registered, high exactly in the cycle sw_out takes its new value.
//     It is the OR of the per-bit update enables delayed to align with sw_out.
//   - A toggle faster than STABLE_CYCLES never propagates; sw_out keeps its old value.
//   - Reset asserted mid-PENDING: counters cleared immediately; no pulse is emitted.
//     After release, sw_out restarts from 0 and a held-high switch is re-accepted with full latency.
// CONFIGURATION
//   SWITCH_EDGE_EN defined:
//     - sw_rise port exists.
//     - sw_rise[i] pulses for one cycle, aligned with sw_changed, when sw_out[i] goes 0->1.
//     - No pulse on 1->0.
//   SWITCH_EDGE_EN undefined: sw_rise port and its flops are absent; all other behaviour identical.
// TESTING (bench uses WIDTH=4, SYNC_STAGES=2, STABLE_CYCLES=4)
//   - Reset values: hold rst_n=0, sw_raw=4'hF -> sw_out=0, sw_changed=0, sw_rise=0 for the whole reset.
//   - Clean change: sw_raw 0->4'h5 at cycle 0 -> sw_out=4'h5 at edge 7; sw_changed=1 for exactly that cycle.
//   - Glitch rejection: bit0 high for 3 cycles, then low -> sw_out stays 0; sw_changed never asserts.
//   - Mixed timing: bit1 set at cycle 0, bit2 set at cycle 2.
//     - sw_out=4'h2 at edge 7, then 4'h6 at edge 9.
//     - Two separate sw_changed pulses.
//   - Reset mid-pending: sw_raw=4'h8, rst_n=0 at cycle 4 for 2 cycles, then release.
//     - sw_out=0 throughout reset; sw_out=4'h8 exactly 7 edges after release.
//   - Edge option (SWITCH_EDGE_EN): sw_raw 0->4'h3->4'h1 with holds of 10 cycles.
//     - sw_rise=4'h3 pulse on the first update; no sw_rise on the second update.
//     - sw_changed pulses on both updates.

Source files
------------

// File: rtl/switch_conditioner.sv
// Switch conditioner: per-bit synchronizer + debounce filter feeding io.switch, with change strobe.
// Optional per-bit rising-edge pulses on sw_rise when SWITCH_EDGE_EN is defined.
module switch_conditioner #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic             sw_changed
`ifdef SWITCH_EDGE_EN
  ,
  output logic [WIDTH-1:0] sw_rise
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {ST_STABLE, ST_PENDING} state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] diff_w;
  logic [WIDTH-1:0] upd;
  state_t           state_q [WIDTH];
  state_t           state_d [WIDTH];
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [CW-1:0]    cnt_d   [WIDTH];

  assign sync_w = sync_q[SYNC_STAGES-1];
  assign diff_w = sync_w ^ sw_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sw_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    upd = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_STABLE: begin
          if (diff_w[i]) begin
            state_d[i] = ST_PENDING;
            cnt_d[i]   = CW'(1);
          end
        end
        ST_PENDING: begin
          if (!diff_w[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CW'(STABLE_CYCLES)) begin
            upd[i]     = 1'b1;
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Strobes are registered from the same enables that load sw_out, so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
      sw_out     <= '0;
      sw_changed <= 1'b0;
`ifdef SWITCH_EDGE_EN
      sw_rise    <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sw_out     <= (sw_out & ~upd) | (sync_w & upd);
      sw_changed <= |upd;
`ifdef SWITCH_EDGE_EN
      sw_rise    <= upd & sync_w;
`endif
    end
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench for switch_conditioner (WIDTH=4, SYNC_STAGES=2, STABLE_CYCLES=4).
// Expected per-edge values are queued when stimulus is driven and compared one edge at a time.
module tb_switch_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_raw;
  logic [3:0] sw_out;
  logic       sw_changed;
`ifdef SWITCH_EDGE_EN
  logic [3:0] sw_rise;
`endif

  typedef struct {
    logic [3:0] out;
    logic       chg;
    logic [3:0] rise;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp;
  int   n_err;

  switch_conditioner #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .STABLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_raw(sw_raw),
    .sw_out(sw_out),
    .sw_changed(sw_changed)
`ifdef SWITCH_EDGE_EN
    ,
    .sw_rise(sw_rise)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT freshly out of reset; the next posedge is edge 1 of the following test.
  task automatic do_reset();
    rst_n  = 1'b0;
    sw_raw = 4'h0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  function automatic exp_t mk(logic [3:0] o, logic c, logic [3:0] r);
    exp_t x;
    x.out  = o;
    x.chg  = c;
    x.rise = r;
    return x;
  endfunction

  task automatic test_reset();
    rst_n  = 1'b0;
    sw_raw = 4'hF;
    #1;
    for (int k = 0; k < 6; k++) exp_q.push_back(mk(4'h0, 1'b0, 4'h0));
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (sw_out !== e.out || sw_changed !== e.chg) begin
        n_err++;
        $display("FAIL reset k=%0d: got out=%h chg=%b, want out=%h chg=%b", k, sw_out, sw_changed, e.out, e.chg);
      end
`ifdef SWITCH_EDGE_EN
      n_cmp++;
      if (sw_rise !== e.rise) begin
        n_err++;
        $display("FAIL reset_rise k=%0d: got %h, want %h", k, sw_rise, e.rise);
      end
`endif
    end
  endtask

  task automatic test_clean_change();
    do_reset();
    sw_raw = 4'h5;
    for (int k = 1; k <= 10; k++)
      exp_q.push_back(mk((k >= 7) ? 4'h5 : 4'h0, k == 7, 4'h0));
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (sw_out !== e.out || sw_changed !== e.chg) begin
        n_err++;
        $display("FAIL clean edge=%0d: got out=%h chg=%b, want out=%h chg=%b", k, sw_out, sw_changed, e.out, e.chg);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    sw_raw = 4'h1;
    for (int k = 1; k <= 14; k++) exp_q.push_back(mk(4'h0, 1'b0, 4'h0));
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 3) sw_raw = 4'h0;
      e = exp_q.pop_front();
      n_cmp++;
      if (sw_out !== e.out || sw_changed !== e.chg) begin
        n_err++;
        $display("FAIL glitch edge=%0d: got out=%h chg=%b, want out=%h chg=%b", k, sw_out, sw_changed, e.out, e.chg);
      end
    end
  endtask

  task automatic test_mixed_timing();
    int pulses;
    pulses = 0;
    do_reset();
    sw_raw = 4'h2;
    for (int k = 1; k <= 12; k++)
      exp_q.push_back(mk((k >= 9) ? 4'h6 : (k >= 7) ? 4'h2 : 4'h0, (k == 7) || (k == 9), 4'h0));
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2) sw_raw = 4'h6;
      if (sw_changed === 1'b1) pulses++;
      e = exp_q.pop_front();
      n_cmp++;
      if (sw_out !== e.out || sw_changed !== e.chg) begin
        n_err++;
        $display("FAIL mixed edge=%0d: got out=%h chg=%b, want out=%h chg=%b", k, sw_out, sw_changed, e.out, e.chg);
      end
    end
    n_cmp++;
    if (pulses !== 2) begin
      n_err++;
      $display("FAIL mixed_pulses: got %0d, want 2", pulses);
    end
  endtask

  task automatic test_reset_mid_pending();
    do_reset();
    sw_raw = 4'h8;
    for (int k = 1; k <= 4; k++) exp_q.push_back(mk(4'h0, 1'b0, 4'h0));
    for (int k = 1; k <= 4; k++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (sw_out !== e.out || sw_changed !== e.chg) begin
        n_err++;
        $display("FAIL midrst_pre edge=%0d: got out=%h chg=%b, want out=%h chg=%b", k, sw_out, sw_changed, e.out, e.chg);
      end
    end
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (sw_out !== 4'h0 || sw_changed !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_hold k=%0d: got out=%h chg=%b, want out=0 chg=0", k, sw_out, sw_changed);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++)
      exp_q.push_back(mk((k >= 7) ? 4'h8 : 4'h0, k == 7, 4'h0));
    for (int k = 1; k <= 9; k++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (sw_out !== e.out || sw_changed !== e.chg) begin
        n_err++;
        $display("FAIL midrst_post edge=%0d: got out=%h chg=%b, want out=%h chg=%b", k, sw_out, sw_changed, e.out, e.chg);
      end
    end
  endtask

`ifdef SWITCH_EDGE_EN
  task automatic test_edge_option();
    do_reset();
    sw_raw = 4'h3;
    for (int k = 1; k <= 20; k++)
      exp_q.push_back(mk((k >= 17) ? 4'h1 : (k >= 7) ? 4'h3 : 4'h0,
                         (k == 7) || (k == 17), (k == 7) ? 4'h3 : 4'h0));
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 10) sw_raw = 4'h1;
      e = exp_q.pop_front();
      n_cmp++;
      if (sw_out !== e.out || sw_changed !== e.chg || sw_rise !== e.rise) begin
        n_err++;
        $display("FAIL edge_opt edge=%0d: got out=%h chg=%b rise=%h, want out=%h chg=%b rise=%h",
                 k, sw_out, sw_changed, sw_rise, e.out, e.chg, e.rise);
      end
    end
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    sw_raw = 4'h0;
    test_reset();
    test_clean_change();
    test_glitch();
    test_mixed_timing();
    test_reset_mid_pending();
`ifdef SWITCH_EDGE_EN
    test_edge_option();
`endif
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
